// File: rtl/dot_matrix_pkg.sv
// Shared constants and scan state encoding for the 16x16 LED dot matrix.
package dot_matrix_pkg;

   localparam int MATRIX_ROWS = 16;
   localparam int MATRIX_COLS = 16;
   localparam int ROW_IDX_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } scan_state_t;

endpackage

// File: rtl/col_rotate16.sv
// Combinational 16-bit barrel rotate, left (dir=0) or right (dir=1).
module col_rotate16
   import dot_matrix_pkg::*;
(
   input  logic [MATRIX_COLS-1:0] data_i,
   input  logic [3:0]             amount_i,
   input  logic                   dir_i,
   output logic [MATRIX_COLS-1:0] data_o
);

   logic [2*MATRIX_COLS-1:0] dbl_w;
   logic [2*MATRIX_COLS-1:0] shl_w;
   logic [2*MATRIX_COLS-1:0] shr_w;

   // Shifting a doubled word turns a rotate into a plain shift.
   assign dbl_w  = {data_i, data_i};
   assign shl_w  = dbl_w << amount_i;
   assign shr_w  = dbl_w >> amount_i;
   assign data_o = dir_i ? shr_w[MATRIX_COLS-1:0]
                         : shl_w[2*MATRIX_COLS-1:MATRIX_COLS];

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row scanner for the 16x16 LED matrix: blank/show timing, frame
// counting and horizontal scroll by rotating each latched column word.
module dot_matrix_scanner
   import dot_matrix_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int STEP_FRAMES  = 32,
   parameter int ROW_ACT_LOW  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   scroll_en,
   input  logic                   scroll_dir,
   output logic [ROW_IDX_W-1:0]   row_bin,
   input  logic [MATRIX_COLS-1:0] col_in,
   output logic [MATRIX_ROWS-1:0] row,
   output logic [MATRIX_COLS-1:0] col_out,
   output logic                   frame_done
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                          : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int FC_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [FC_W-1:0]  STEP_LAST  = FC_W'(STEP_FRAMES - 1);
   localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(MATRIX_ROWS - 1);

   localparam logic [MATRIX_ROWS-1:0] ROW_OFF =
      (ROW_ACT_LOW != 0) ? {MATRIX_ROWS{1'b1}} : {MATRIX_ROWS{1'b0}};

   scan_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ROW_IDX_W-1:0]   row_bin_q, row_bin_d;
   logic [MATRIX_ROWS-1:0] row_q, row_d;
   logic [MATRIX_COLS-1:0] col_q, col_d;
   logic                   fd_q, fd_d;
   logic [3:0]             offset_q, offset_d;
   logic [FC_W-1:0]        fcnt_q, fcnt_d;

   logic [MATRIX_ROWS-1:0] row_on_w;
   logic [MATRIX_COLS-1:0] rot_w;

   assign row_on_w = ROW_OFF ^ (MATRIX_ROWS'(1) << row_bin_q);

   col_rotate16 u_rot (
      .data_i   (col_in),
      .amount_i (offset_q),
      .dir_i    (scroll_dir),
      .data_o   (rot_w)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      row_bin_d = row_bin_q;
      row_d     = row_q;
      col_d     = col_q;
      fd_d      = 1'b0;
      offset_d  = offset_q;
      fcnt_d    = fcnt_q;
      if (!en) begin
         state_d   = IDLE;
         cnt_d     = '0;
         row_bin_d = '0;
         row_d     = ROW_OFF;
         col_d     = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = BLANK;
               cnt_d     = '0;
               row_bin_d = '0;
               row_d     = ROW_OFF;
               col_d     = '0;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = SHOW;
                  cnt_d   = '0;
                  row_d   = row_on_w;
                  col_d   = rot_w;
               end
            end
            SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  state_d   = BLANK;
                  cnt_d     = '0;
                  row_bin_d = row_bin_q + 1'b1;
                  row_d     = ROW_OFF;
                  col_d     = '0;
                  if (row_bin_q == LAST_ROW) begin
                     fd_d = 1'b1;
                     if (fcnt_q == STEP_LAST) begin
                        fcnt_d = '0;
                        if (scroll_en) begin
                           offset_d = scroll_dir ? offset_q - 4'd1
                                                 : offset_q + 4'd1;
                        end
                     end else begin
                        fcnt_d = fcnt_q + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         row_bin_q <= '0;
         row_q     <= ROW_OFF;
         col_q     <= '0;
         fd_q      <= 1'b0;
         offset_q  <= '0;
         fcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_bin_q <= row_bin_d;
         row_q     <= row_d;
         col_q     <= col_d;
         fd_q      <= fd_d;
         offset_q  <= offset_d;
         fcnt_q    <= fcnt_d;
      end
   end

   assign row_bin    = row_bin_q;
   assign row        = row_q;
   assign col_out    = col_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench: a time-position model of the scan queues expected outputs.
module tb_dot_matrix_scanner;

   localparam int D  = 4;
   localparam int B  = 2;
   localparam int S  = 2;
   localparam int P  = B + D;
   localparam int FP = 16 * P;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic scroll_en = 1'b0;
   logic scroll_dir = 1'b0;

   logic [3:0]  rb_a, rb_b;
   logic [15:0] ci_a, ci_b, row_a, row_b, co_a, co_b;
   logic        fd_a, fd_b;
   logic [15:0] rom [16];

   assign ci_a = rom[rb_a];
   assign ci_b = rom[rb_b];

   always #5 clk = ~clk;

   dot_matrix_scanner #(
      .DWELL_CYCLES(D), .BLANK_CYCLES(B),
      .STEP_FRAMES(S), .ROW_ACT_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .scroll_en(scroll_en), .scroll_dir(scroll_dir),
      .row_bin(rb_a), .col_in(ci_a), .row(row_a),
      .col_out(co_a), .frame_done(fd_a)
   );

   dot_matrix_scanner #(
      .DWELL_CYCLES(D), .BLANK_CYCLES(B),
      .STEP_FRAMES(S), .ROW_ACT_LOW(1)
   ) dut_al (
      .clk(clk), .rst(rst), .en(en),
      .scroll_en(scroll_en), .scroll_dir(scroll_dir),
      .row_bin(rb_b), .col_in(ci_b), .row(row_b),
      .col_out(co_b), .frame_done(fd_b)
   );

   typedef struct {
      logic [15:0] row;
      logic [15:0] row_al;
      logic [15:0] col;
      logic [3:0]  rb;
      logic        fd;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   function automatic logic [15:0] rotm(input logic [15:0] x,
                                        input int k,
                                        input logic dir);
      logic [15:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         if (!dir) y[(i + k) % 16] = x[i];
         else      y[(i + 16 - k) % 16] = x[i];
      end
      return y;
   endfunction

   // Model: position p counts edges since the scan left IDLE.
   bit          running = 0;
   int          p = 0;
   int          off = 0;
   int          fc = 0;
   logic [15:0] lcol = '0;

   always @(posedge clk) begin : model
      exp_t        e;
      logic        fd;
      logic [15:0] oh;
      int          r;
      fd = 1'b0;
      if (rst) begin
         running = 0;
         off = 0;
         fc = 0;
      end else if (!en) begin
         running = 0;
      end else if (!running) begin
         running = 1;
         p = 0;
      end else begin
         p++;
         if (p % FP == 0) begin
            fd = 1'b1;
            if (fc == S - 1) begin
               fc = 0;
               if (scroll_en) off = scroll_dir ? (off + 15) % 16 : (off + 1) % 16;
            end else begin
               fc++;
            end
         end
         if (p % P == B) lcol = rotm(rom[(p / P) % 16], off, scroll_dir);
      end
      e.fd = fd;
      if (!running) begin
         e.rb = 4'd0;
         e.row = 16'h0000;
         e.row_al = 16'hFFFF;
         e.col = 16'h0000;
      end else begin
         r = (p / P) % 16;
         e.rb = 4'(r);
         if (p % P >= B) begin
            oh = 16'h0001 << r;
            e.row = oh;
            e.row_al = ~oh;
            e.col = lcol;
         end else begin
            e.row = 16'h0000;
            e.row_al = 16'hFFFF;
            e.col = 16'h0000;
         end
      end
      q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if (row_a !== e.row || row_b !== e.row_al || co_a !== e.col ||
             co_b !== e.col || rb_a !== e.rb || rb_b !== e.rb ||
             fd_a !== e.fd || fd_b !== e.fd) begin
            miscompares++;
            $display("FAIL scan t=%0t got row=%h rowal=%h col=%h/%h rb=%h/%h fd=%b/%b exp row=%h rowal=%h col=%h rb=%h fd=%b",
                     $time, row_a, row_b, co_a, co_b, rb_a, rb_b, fd_a, fd_b,
                     e.row, e.row_al, e.col, e.rb, e.fd);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // mode 0: row 5 lit; mode 1: row 9 blanking
   task automatic wait_until(input int mode, input int budget);
      bit hit;
      hit = 0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         if (mode == 0) hit = (row_a === 16'h0020);
         else           hit = (rb_a === 4'd9 && row_a === 16'h0000);
      end
      if (!hit) begin
         miscompares++;
         $display("FAIL wait_mode%0d timed out after %0d cycles", mode, budget);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
      rom[0]  = 16'h0000;
      rom[1]  = 16'h0810;
      rom[7]  = 16'h0FF0;
      rom[14] = 16'h0000;
      rom[15] = 16'h0000;

      cycles(3);
      rst = 1'b0;
      cycles(2);

      en = 1'b1;
      cycles(2 * FP + 10);

      scroll_en = 1'b1;
      scroll_dir = 1'b0;
      cycles(4 * FP);
      scroll_dir = 1'b1;
      cycles(4 * FP);
      scroll_dir = 1'b0;
      cycles(6 * FP);
      scroll_en = 1'b0;

      wait_until(0, 2 * FP);
      cycles(1);
      en = 1'b0;
      cycles(3);
      en = 1'b1;
      cycles(2 * FP);

      scroll_en = 1'b1;
      cycles(2 * FP);
      wait_until(1, 2 * FP);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(FP + 5);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         en = ($urandom_range(0, 99) != 0);
         scroll_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) scroll_dir = ~scroll_dir;
         rst = ($urandom_range(0, 999) == 0);
      end
      rst = 1'b0;
      en = 1'b1;
      cycles(FP);

      cycles(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
